cpu_clock_controller: RTL

Single-clock controller that turns the divided clock ticks into one CPU clock-enable stream. Inputs are the board clock, the slow divided ticks (debouncer, auto, turbo) and the user controls: a step pushbutton and mode switches. Each tick edge is synchronized and edge-detected. The step button is debounced. Exactly one source is chosen by mode, and a one-cycle `CPU_Clock_Enable` pulse is emitted per selected event. The block sits directly downstream of the clock divider chain and upstream of the CPU datapath enable.

---
 rtl/clk_ctrl_pkg.sv | 30 +++
 rtl/button_debouncer.sv | 105 ++++++++++
 rtl/cpu_clock_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock controller.
// Contents: operating-mode enum, button debouncer state enum, reset mode,
// and bit positions of the three tick sources inside the tick vectors.
package clk_ctrl_pkg;

  // Encodings match the raw Mode switch positions so the synchronized
  // switch value can be cast straight to this type.
  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    TURBO  = 2'b10,
    HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    ARMING_HI = 2'b01,
    STABLE_HI = 2'b10,
    ARMING_LO = 2'b11
  } dbn_state_e;

  // Coming out of reset the CPU must not advance until a mode is committed.
  localparam mode_e RESET_MODE = HOLD;

  // Bit positions within the packed tick vectors.
  localparam int TICK_DBN   = 0;
  localparam int TICK_AUTO  = 1;
  localparam int TICK_TURBO = 2;

endpackage

// File: rtl/button_debouncer.sv
// Step pushbutton synchronizer and debounce FSM.
// Ports: clk/rst (async active-high), button_raw (asynchronous pushbutton),
//        tick (one-cycle sample strobe), level (debounced level), press (one-cycle accept pulse).
module button_debouncer
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int SYNC_STAGES      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  input  logic tick,
  output logic level,
  output logic press
);

  // The arming count is already 1 on entry, so the transition fires when
  // the count equals DEBOUNCE_SAMPLES-1 and one more agreeing sample arrives.
  localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_SAMPLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sample;
  dbn_state_e             state;
  dbn_state_e             state_next;
  logic [3:0]             count;
  logic [3:0]             count_next;

  assign sample = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], button_raw};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE_LO;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic: the FSM only moves on tick cycles.
  always_comb begin
    state_next = state;
    count_next = count;
    if (tick) begin
      case (state)
        STABLE_LO: begin
          if (sample) begin
            state_next = ARMING_HI;
            count_next = 4'd1;
          end
        end
        ARMING_HI: begin
          if (!sample) begin
            state_next = STABLE_LO;
            count_next = '0;
          end else if (count == LAST_COUNT) begin
            state_next = STABLE_HI;
            count_next = '0;
          end else begin
            count_next = count + 4'd1;
          end
        end
        STABLE_HI: begin
          if (!sample) begin
            state_next = ARMING_LO;
            count_next = 4'd1;
          end
        end
        ARMING_LO: begin
          if (sample) begin
            state_next = STABLE_HI;
            count_next = '0;
          end else if (count == LAST_COUNT) begin
            state_next = STABLE_LO;
            count_next = '0;
          end else begin
            count_next = count + 4'd1;
          end
        end
        default: begin
          state_next = STABLE_LO;
          count_next = '0;
        end
      endcase
    end
  end

  // Outputs: press is Mealy so it lines up with the accepting tick; the
  // level flips on the following edge together with the state register.
  always_comb begin
    level = (state == STABLE_HI) || (state == ARMING_LO);
    press = tick && (state == ARMING_HI) && sample && (count == LAST_COUNT);
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// Selects one of the divided tick sources (or the debounced step button) and
// emits a single-cycle CPU clock-enable per selected event, with halt handling.
// Ports: Board_Clock/Reset (async active-high); Debouncer_Clock, Auto_Clock,
//        Turbo_Clock ticks; Step_Button; Mode[1:0]; Halt_Request;
//        CPU_Clock_Enable, Button_Level, Active_Mode[1:0], Halted.
// Optional: define CLKCTRL_STEP_COUNTER_EN to add Step_Count[15:0], a wrapping
//           count of issued enables that clears on every mode commit.
module cpu_clock_controller
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int SYNC_STAGES      = 2
) (
  input  logic        Board_Clock,
  input  logic        Reset,
  input  logic        Debouncer_Clock,
  input  logic        Auto_Clock,
  input  logic        Turbo_Clock,
  input  logic        Step_Button,
  input  logic [1:0]  Mode,
  input  logic        Halt_Request,
  output logic        CPU_Clock_Enable,
  output logic        Button_Level,
  output logic [1:0]  Active_Mode,
  output logic        Halted
`ifdef CLKCTRL_STEP_COUNTER_EN
  ,
  output logic [15:0] Step_Count
`endif
);

  // ---------------------------------------------------------------------
  // Tick synchronizers and registered rising-edge detectors.
  // Tick first sampled on edge N: synchronized after N+SYNC_STAGES-1,
  // edge pulse registered on N+SYNC_STAGES, enable registered one later.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][2:0] tick_chain;
  logic [2:0]                  tick_sync;
  logic [2:0]                  tick_prev;
  logic [2:0]                  tick_rise;

  assign tick_sync = tick_chain[SYNC_STAGES-1];

  always_ff @(posedge Board_Clock or posedge Reset) begin
    if (Reset) begin
      tick_chain <= '0;
      tick_prev  <= '0;
      tick_rise  <= '0;
    end else begin
      tick_chain <= {tick_chain[SYNC_STAGES-2:0], {Turbo_Clock, Auto_Clock, Debouncer_Clock}};
      tick_prev  <= tick_sync;
      tick_rise  <= tick_sync & ~tick_prev;
    end
  end

  // ---------------------------------------------------------------------
  // Mode switch synchronizer
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][1:0] mode_chain;
  mode_e                       mode_sync;

  assign mode_sync = mode_e'(mode_chain[SYNC_STAGES-1]);

  always_ff @(posedge Board_Clock or posedge Reset) begin
    if (Reset) begin
      mode_chain <= '0;
    end else begin
      mode_chain <= {mode_chain[SYNC_STAGES-2:0], Mode};
    end
  end

  // ---------------------------------------------------------------------
  // Step button
  // ---------------------------------------------------------------------
  logic press;

  button_debouncer #(
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .SYNC_STAGES      (SYNC_STAGES)
  ) u_debouncer (
    .clk        (Board_Clock),
    .rst        (Reset),
    .button_raw (Step_Button),
    .tick       (tick_rise[TICK_DBN]),
    .level      (Button_Level),
    .press      (press)
  );

  // ---------------------------------------------------------------------
  // Mode commit, event selection, suppression and halt
  // ---------------------------------------------------------------------
  mode_e active_mode;
  mode_e mode_prev;     // switch value seen on the previous debouncer tick
  logic  suppress;      // drop the first selected event after a commit
  logic  enable_q;

  logic  commit;
  logic  event_sel;
  logic  enable_next;
  logic  halted_next;
  logic  suppress_next;

  always_comb begin
    commit        = 1'b0;
    event_sel     = 1'b0;
    enable_next   = 1'b0;
    halted_next   = Halted;
    suppress_next = suppress;

    // A commit needs the same switch value on two consecutive debouncer
    // ticks; re-committing the mode already in effect would needlessly
    // re-arm suppression, so only real changes count.
    commit = tick_rise[TICK_DBN] && (mode_sync == mode_prev) && (mode_sync != active_mode);

    // Events are always judged against the mode in effect before any
    // commit happening in this same cycle.
    case (active_mode)
      MANUAL:  event_sel = press;
      AUTO:    event_sel = tick_rise[TICK_AUTO];
      TURBO:   event_sel = tick_rise[TICK_TURBO];
      default: event_sel = 1'b0;
    endcase

    // The last term is belt-and-braces: edge pulses already cannot repeat
    // on back-to-back cycles.
    enable_next = event_sel && !suppress && !Halted && !Halt_Request && !enable_q;

    // Halt request wins over a coincident halt-clearing press.
    if (Halt_Request) begin
      halted_next = 1'b1;
    end else if (Halted && press && (active_mode == MANUAL)) begin
      halted_next = 1'b0;
    end

    // Any selected event consumes a pending suppression, including one that
    // is swallowed by halt; a commit in the same cycle re-arms it.
    if (commit) begin
      suppress_next = 1'b1;
    end else if (event_sel) begin
      suppress_next = 1'b0;
    end
  end

  always_ff @(posedge Board_Clock or posedge Reset) begin
    if (Reset) begin
      active_mode <= RESET_MODE;
      mode_prev   <= RESET_MODE;
      suppress    <= 1'b0;
      Halted      <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      if (tick_rise[TICK_DBN]) begin
        mode_prev <= mode_sync;
      end
      if (commit) begin
        active_mode <= mode_sync;
      end
      suppress <= suppress_next;
      Halted   <= halted_next;
      enable_q <= enable_next;
    end
  end

  assign CPU_Clock_Enable = enable_q;
  assign Active_Mode      = active_mode;

`ifdef CLKCTRL_STEP_COUNTER_EN
  // Counts alongside the enable register; a commit restarts the count.
  always_ff @(posedge Board_Clock or posedge Reset) begin
    if (Reset) begin
      Step_Count <= '0;
    end else if (commit) begin
      Step_Count <= '0;
    end else if (enable_next) begin
      Step_Count <= Step_Count + 16'd1;
    end
  end
`endif

endmodule
